// File: rtl/aug_pkg.sv
// Shared types and defaults for the image augmentation stages.
// Rotation modes are ordered so the raw 2-bit code equals quarter-turns clockwise.
package aug_pkg;

   typedef enum logic [1:0] {
      ROT_0,
      ROT_90,
      ROT_180,
      ROT_270
   } rot_mode_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   localparam int PIXEL_W_DEFAULT = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rotation_augment_if.sv
// Pixel-stream and BRAM read signals of the rotation stage.
// The master side is the rotation stage; the slave side is the BRAM plus pixel sink.
interface rotation_augment_if
   import aug_pkg::*;
#(
   parameter int PIXEL_W = PIXEL_W_DEFAULT
) ();

   logic [PIXEL_W-1:0] pixel_o;
   logic               pixel_valid;
   logic               pixel_ready;
   logic [31:0]        bram_address;
   logic [31:0]        bram_data;

   modport master (
      output pixel_o, pixel_valid, bram_address,
      input  pixel_ready, bram_data
   );

   modport slave (
      input  pixel_o, pixel_valid, bram_address,
      output pixel_ready, bram_data
   );

endinterface

// File: rtl/aug_pixel_fifo.sv
// Synchronous FIFO with occupancy count, shared by the augmentation stages.
// The head reads as zero while empty so downstream never sees uninitialised storage.
module aug_pixel_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [PTR_W-1:0] ptr_t;

   logic [WIDTH-1:0] mem [DEPTH];
   ptr_t             rd_ptr;
   ptr_t             wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic ptr_t next_ptr(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // A pop frees the slot a simultaneous push needs, so full+push+pop is legal;
   // on empty the pair cancels and the count stays put.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && (!empty || push);

   assign head = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rotation_augment.sv
// Streams one stored image out of pixel BRAM rotated by a multiple of 90 deg clockwise,
// optionally mirrored, with credit-based read issue so the output FIFO never overflows.
module rotation_augment
   import aug_pkg::*;
#(
   parameter int IMG_W        = 28,
   parameter int IMG_H        = 28,
   parameter int PIXEL_W      = PIXEL_W_DEFAULT,
   parameter int BASE_ADDR    = 0,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  rot_mode_t          mode,
   input  logic               flip,
   output logic               busy,
   output logic               image_done,
   rotation_augment_if.master bus
);

   localparam int MAX_DIM = max_int(IMG_W, IMG_H);
   localparam int CNT_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
   localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int IF_W    = $clog2(READ_LATENCY + 1);

   typedef logic [CNT_W-1:0] idx_t;

   localparam idx_t W_M1 = idx_t'(IMG_W - 1);
   localparam idx_t H_M1 = idx_t'(IMG_H - 1);

   state_t                   state;
   state_t                   state_next;
   rot_mode_t                mode_q;
   logic                     flip_q;
   idx_t                     row;
   idx_t                     col;
   idx_t                     rows_m1;
   idx_t                     cols_m1;
   idx_t                     col_eff;
   idx_t                     src_row;
   idx_t                     src_col;
   logic [READ_LATENCY-1:0]  in_flight;
   logic [IF_W-1:0]          in_flight_cnt;
   logic                     credit_ok;
   logic                     issue;
   logic                     last_issue;
   logic                     pop;
   logic                     last_pop;
   logic [FCNT_W-1:0]        fifo_count;
   logic                     fifo_empty;
   logic                     fifo_full;
   logic                     unused;

   assign unused = &{1'b0, fifo_full, bus.bram_data[31:PIXEL_W]};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rows_m1 = H_M1;
      cols_m1 = W_M1;
      if (mode_q == ROT_90 || mode_q == ROT_270) begin
         rows_m1 = W_M1;
         cols_m1 = H_M1;
      end
      col_eff = flip_q ? (cols_m1 - col) : col;

      src_row = row;
      src_col = col_eff;
      unique case (mode_q)
         ROT_0: begin
            src_row = row;
            src_col = col_eff;
         end
         ROT_90: begin
            src_row = H_M1 - col_eff;
            src_col = row;
         end
         ROT_180: begin
            src_row = H_M1 - row;
            src_col = W_M1 - col_eff;
         end
         default: begin
            src_row = col_eff;
            src_col = W_M1 - row;
         end
      endcase
   end

   assign bus.bram_address = 32'(BASE_ADDR) + 32'(src_row) * 32'(IMG_W) + 32'(src_col);

   // Outstanding reads count against the FIFO so every returning word has a slot.
   always_comb begin
      in_flight_cnt = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         in_flight_cnt += IF_W'(in_flight[i]);
      end
   end

   assign credit_ok  = (32'(fifo_count) + 32'(in_flight_cnt)) < 32'(FIFO_DEPTH);
   assign issue      = (state == ISSUE) && credit_ok;
   assign last_issue = issue && (row == rows_m1) && (col == cols_m1);
   assign pop        = bus.pixel_valid && bus.pixel_ready;
   assign last_pop   = (state == DRAIN) && pop && (fifo_count == FCNT_W'(1)) && (in_flight == '0);

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = ISSUE;
         ISSUE:   if (last_issue) state_next = DRAIN;
         // Leave DRAIN only after the done pulse, so a start coinciding with it is ignored.
         DRAIN:   if (image_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         mode_q     <= ROT_0;
         flip_q     <= 1'b0;
         row        <= '0;
         col        <= '0;
         busy       <= 1'b0;
         image_done <= 1'b0;
         in_flight  <= '0;
      end else begin
         state      <= state_next;
         image_done <= last_pop;

         in_flight[0] <= issue;
         for (int i = 1; i < READ_LATENCY; i++) begin
            in_flight[i] <= in_flight[i-1];
         end

         if (state == IDLE && start) begin
            mode_q <= mode;
            flip_q <= flip;
            row    <= '0;
            col    <= '0;
            busy   <= 1'b1;
         end else if (issue && !last_issue) begin
            if (col == cols_m1) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end

         if (last_pop) busy <= 1'b0;
      end
   end

   aug_pixel_fifo #(
      .WIDTH (PIXEL_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_flight[READ_LATENCY-1]),
      .pop   (pop),
      .din   (bus.bram_data[PIXEL_W-1:0]),
      .head  (bus.pixel_o),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.pixel_valid = !fifo_empty;

endmodule
